division_recombine: RTL and testbench

Sequential inverse of the team's combinational 8-bit divide/modulus block. It takes a quotient, divisor and remainder and rebuilds the dividend as `quotient*divisor + remainder` using an 8-cycle shift-add datapath. It also flags remainders that are illegal for the given divisor. It sits downstream of the divider, both as a round-trip checker and as a reconstruction unit, with valid/ready handshakes on both sides.

---
 rtl/division_recombine.sv | 94 +++++++++
 tb/tb_division_recombine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/division_recombine.sv
// Sequential inverse of the 8-bit divider: rebuilds q*d + r with an 8-cycle shift-add datapath
// and flags remainders that are illegal for the divisor (r >= d, including d == 0).
module division_recombine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  q,
    input  logic [7:0]  d,
    input  logic [7:0]  r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  mq_q, mq_d;
    logic [15:0] md_q, md_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] p_q, p_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] acc_sum;

    always_comb begin
        state_d = state_q;
        mq_d    = mq_q;
        md_d    = md_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc_sum = acc_q + (mq_q[0] ? md_q : 16'd0);

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mq_d    = q;
                    md_d    = {8'b0, d};
                    acc_d   = {8'b0, r};
                    cnt_d   = 3'd0;
                    err_d   = (r >= d);
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_sum;
                md_d  = md_q << 1;
                mq_d  = mq_q >> 1;
                cnt_d = cnt_q + 3'd1;
                // Fixed 8 iterations; the last partial sum goes straight to the result register.
                if (cnt_q == 3'd7) begin
                    p_d     = acc_sum;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mq_q    <= 8'd0;
            md_q    <= 16'd0;
            acc_q   <= 16'd0;
            p_q     <= 16'd0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mq_q    <= mq_d;
            md_q    <= md_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign p         = p_q;
    assign err       = err_q;

endmodule

// File: tb/tb_division_recombine.sv
// Bench for division_recombine: directed vector table, busy/reset sequences and random
// operations checked against the arithmetic definition q*d + r and r >= d.
module tb_division_recombine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        err;

    int checks;
    int errors;

    division_recombine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  vq;
        logic [7:0]  vd;
        logic [7:0]  vr;
        int          hold;
        logic [15:0] exp_p;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full transaction: accept, count latency, hold under backpressure, then handshake.
    task automatic run_op(input logic [7:0] tq, input logic [7:0] td, input logic [7:0] tr,
                          input int hold, output logic [15:0] gp, output logic gerr);
        int   n;
        logic overlap;
        logic unstable;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        q = tq; d = td; r = tr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        overlap = 1'b0;
        while (!out_valid && n < 20) begin
            if (in_ready) overlap = 1'b1;
            @(posedge clk); #1; n++;
        end
        check("latency", n, 8);
        check("no_ready_while_busy", overlap, 0);
        gp = p;
        gerr = err;
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || p !== gp || err !== gerr) unstable = 1'b1;
        end
        check("hold_stable", unstable, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_handshake", {out_valid, in_ready}, 2'b01);
    endtask

    vec_t        vecs[7];
    logic [15:0] gp;
    logic        gerr;
    int          n;
    logic        seen;
    logic [7:0]  rq, rd, rr;
    int          hold;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q = 8'd0; d = 8'd0; r = 8'd0;

        vecs[0] = '{8'd7,   8'd5,   8'd3,   0, 16'd38,    1'b0};
        vecs[1] = '{8'd255, 8'd255, 8'd254, 0, 16'd65279, 1'b0};
        vecs[2] = '{8'd0,   8'd200, 8'd0,   0, 16'd0,     1'b0};
        vecs[3] = '{8'd17,  8'd0,   8'd9,   0, 16'd9,     1'b1};
        vecs[4] = '{8'd1,   8'd4,   8'd4,   0, 16'd8,     1'b1};
        vecs[5] = '{8'd12,  8'd10,  8'd6,   5, 16'd126,   1'b0};
        vecs[6] = '{8'd3,   8'd3,   8'd2,   1, 16'd11,    1'b0};

        // Reset values
        @(posedge clk); #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_p", p, 0);
        check("reset_err", err, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].vq, vecs[i].vd, vecs[i].vr, vecs[i].hold, gp, gerr);
            check("vec_p", gp, vecs[i].exp_p);
            check("vec_err", gerr, vecs[i].exp_err);
        end

        // in_valid held with changing operands while busy: only the first set is used
        q = 8'd5; d = 8'd6; r = 8'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_accepted", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
            @(posedge clk); #1; n++;
        end
        check("busy_latency", n, 8);
        for (int i = 0; i < 2; i++) begin
            q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
            @(posedge clk); #1;
        end
        check("busy_done_ready_low", {out_valid, in_ready}, 2'b10);
        check("busy_p", p, 31);
        check("busy_err", err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("busy_back_idle", in_ready, 1);
        q = 8'd9; d = 8'd8; r = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_second_accept", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("second_p", p, 79);
        check("second_err", err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during RUN discards the computation
        q = 8'd200; d = 8'd9; r = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_p", p, 0);
        check("midreset_err", err, 0);
        check("midreset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("midreset_idle", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midreset_no_output", seen, 0);
        run_op(8'd3, 8'd3, 8'd2, 0, gp, gerr);
        check("post_reset_p", gp, 11);
        check("post_reset_err", gerr, 0);

        // Random operations against the arithmetic definition
        for (int i = 0; i < 40; i++) begin
            rq = 8'($urandom);
            rd = (i % 8 == 0) ? 8'd0 : 8'($urandom);
            rr = (i % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            hold = int'($urandom_range(0, 3));
            run_op(rq, rd, rr, hold, gp, gerr);
            check("rand_p", gp, int'(rq) * int'(rd) + int'(rr));
            check("rand_err", gerr, (int'(rr) >= int'(rd)) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
